// File: rtl/dmem_responder.sv
// dmem_responder
//    Multi-cycle data-memory slave for the MEM stage of the pipelined CPU.
//    A request is accepted in IDLE and acknowledged LATENCY cycles later with
//    a one-cycle ack. The pipeline is stalled while the access is in flight.
//    Misaligned and out-of-range accesses are flagged with err_o.
//
// Ports
//    clk_i    clock, all state changes on the rising edge
//    rst_i    synchronous active-high reset (storage contents are kept)
//    req_i    access request, held by the requester until ack_o
//    we_i     1 = store, 0 = load (sampled with req_i in IDLE)
//    addr_i   byte address (sampled with req_i in IDLE)
//    data_i   store data (sampled with req_i in IDLE)
//    ack_o    one-cycle completion pulse
//    data_o   load data, valid while ack_o=1 for a load
//    stall_o  freeze request to PC / pipeline registers
//    err_o    access fault, pulses together with ack_o

module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] count;

   logic          cap_we;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_data;

   logic [31:0]   mem [DEPTH];

   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_data;
   logic          fault;
   logic          enter_done;
   logic [AW-1:0] idx;

   always_comb begin
      state_next = state;
      stall_o    = 1'b0;
      case (state)
         IDLE: begin
            if (req_i) begin
               stall_o    = 1'b1;
               state_next = (LATENCY == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            stall_o = 1'b1;
            if (count == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // With LATENCY==1 the access completes on the same edge that accepts the
   // request, before the captured copies exist, so IDLE uses the live inputs.
   always_comb begin
      acc_we   = cap_we;
      acc_addr = cap_addr;
      acc_data = cap_data;
      if (state == IDLE) begin
         acc_we   = we_i;
         acc_addr = addr_i;
         acc_data = data_i;
      end
      fault      = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
      idx        = acc_addr[AW+1:2];
      enter_done = (state_next == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         count    <= '0;
         cap_we   <= 1'b0;
         cap_addr <= '0;
         cap_data <= '0;
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         data_o   <= '0;
      end else begin
         state <= state_next;
         ack_o <= enter_done;
         err_o <= enter_done & fault;
         case (state)
            IDLE: begin
               if (req_i) begin
                  cap_we   <= we_i;
                  cap_addr <= addr_i;
                  cap_data <= data_i;
                  count    <= CW'(LATENCY - 1);
               end
            end
            WAIT: begin
               count <= count - CW'(1);
            end
            default: begin
            end
         endcase
         // A store leaves data_o untouched; a fault forces it to zero.
         if (enter_done) begin
            if (fault) begin
               data_o <= '0;
            end else if (!acc_we) begin
               data_o <= mem[idx];
            end
         end
      end
   end

   // The array has no reset so its contents survive rst_i, but a reset on
   // the committing edge abandons the store.
   always_ff @(posedge clk_i) begin
      if (!rst_i && enter_done && acc_we && !fault) begin
         mem[idx] <= acc_data;
      end
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that serves the load/store requests issued by the pipelined CPU's MEM stage. It replaces the single-cycle data memory with a request/acknowledge slave of configurable latency. While an access is in flight it asserts a stall back to the pipeline, then returns read data with a one-cycle ack. It also flags misaligned and out-of-range accesses.

Parameters:
DEPTH, 256, number of 32-bit words in the storage array (power of two, >= 2)
LATENCY, 4, cycles from request acceptance to ack (integer >= 1)

Ports:
clk_i  input  1  clock, all state changes on rising edge
rst_i  input  1  reset, synchronous, active-high
req_i  input  1  access request from MEM stage; held high by the requester until ack_o
we_i  input  1  1 = store, 0 = load; sampled with req_i in IDLE
addr_i  input  32  byte address; sampled with req_i in IDLE
data_i  input  32  store data; sampled with req_i in IDLE
ack_o  output  1  one-cycle completion pulse
data_o  output  32  load data, valid while ack_o=1 for a load
stall_o  output  1  freeze request to PC / pipeline registers
err_o  output  1  access fault, pulses together with ack_o

Behaviour:
- Reset (synchronous, rst_i=1 at edge): state=IDLE, counter=0, ack_o=0, err_o=0, data_o=0, captured regs=0. Storage array is not cleared; contents survive reset.
- Reset mid-operation: the in-flight access is abandoned. A pending store is not written, and no ack is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE, req_i=1 at edge:
  - capture we_i, addr_i, data_i
  - load counter = LATENCY-1
  - next state = DONE if LATENCY==1, else WAIT
- IDLE, req_i=0: stay in IDLE.
- WAIT: counter decrements each edge. When counter==1 at an edge, next state = DONE. WAIT lasts exactly LATENCY-1 cycles. req_i, we_i, addr_i and data_i are ignored in WAIT, because the captured copies are used.
- Transition into DONE (same edge), using the captured request:
  - fault = captured addr[1:0]!=0 OR word index addr[31:2] >= DEPTH
  - store, no fault: mem[addr[log2(DEPTH)+1:2]] <= data
  - load, no fault: data_o <= mem[index]
  - any fault: data_o <= 0, no write, err_o <= 1
  - store, no fault: data_o is unchanged
- DONE: ack_o=1 for exactly this cycle. Next edge returns unconditionally to IDLE. req_i seen during DONE is ignored; a new request is accepted only in IDLE, at the earliest one cycle after ack.
- ack_o and err_o are registered: high only in DONE, otherwise 0.
- data_o holds its last loaded value outside DONE.
- stall_o is combinational: stall_o = (state==IDLE & req_i) | (state==WAIT). It is 0 in DONE, so the pipeline advances on the ack cycle.
- Latency: request first seen high in IDLE during cycle k gives ack_o=1 in cycle k+LATENCY, with stall_o=1 in cycles k..k+LATENCY-1.
- Back-to-back requests: throughput is one access per LATENCY+1 cycles.
- Read-after-write to the same address returns the new data, because the store commits on the edge entering DONE.
- Counter width: enough bits for LATENCY-1. No wrap-around is possible, because the counter is reloaded only in IDLE.

Test Plan:
1. LATENCY=4. Reset, then store addr=0x10 data=0xDEADBEEF at cycle 2 → stall_o=1 in cycles 2..5, ack_o=1 and err_o=0 in cycle 6, stall_o=0 in cycle 6. Then load 0x10 → ack 4 cycles after the request with data_o=0xDEADBEEF.
2. LATENCY=1. Store 0x4=0x1234, then load 0x4 held until ack → each access acks the cycle after the request. Load returns 0x00001234. One idle cycle separates the two acks.
3. Misaligned load addr=0x6, then store addr=4*DEPTH (0x400 for DEPTH=256) → err_o=1 with ack_o for both, data_o=0. Subsequent load of 0x0 shows the word unchanged.
4. Start store 0x20=0xA5A5A5A5, assert rst_i in the second WAIT cycle → no ack, state returns to IDLE. A later load of 0x20 returns the prior contents, not 0xA5A5A5A5.
5. Hold req_i high continuously with changing addr_i/data_i during WAIT and DONE → only values sampled in IDLE are used. Exactly one ack per LATENCY+1 cycles, and stall_o=0 only on ack cycles.
6. Store 0x8=0x55, then reset, then load 0x8 → returns 0x55 (array survives reset), and data_o reads 0 between the reset and the ack.
